// File: rtl/sqrt_seq_master.sv
// rtl/sqrt_seq_master.sv - st/done handshake initiator walking an operand table into the sqrt unit
// Optional result self-check built only when SQRT_SEQ_CHECK_EN is defined.
module sqrt_seq_master #(
    parameter int NUM_VEC = 16,
    parameter int N_W     = 8,
    parameter int R_W     = 4,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           go,
    output logic [7:0]     vec_addr,
    input  logic [N_W-1:0] vec_data,
    output logic           st,
    output logic [N_W-1:0] n,
    input  logic           done,
    input  logic [R_W-1:0] sqrt,
    output logic           busy,
    output logic           res_valid,
    output logic [7:0]     res_idx,
    output logic [N_W-1:0] res_n,
    output logic [R_W-1:0] res_sqrt,
    output logic           res_ok,
    output logic [7:0]     err_count,
    output logic           timeout,
    output logic           run_done
);

    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [7:0]       IDX_LAST = 8'(NUM_VEC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_REQ,
        S_REL,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    logic [N_W-1:0]   n_q, n_d;
    logic             st_q, st_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       res_idx_q, res_idx_d;
    logic [N_W-1:0]   res_n_q, res_n_d;
    logic [R_W-1:0]   res_sqrt_q, res_sqrt_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        n_d         = n_q;
        st_d        = st_q;
        tmo_d       = tmo_q;
        res_valid_d = 1'b0;
        res_idx_d   = res_idx_q;
        res_n_d     = res_n_q;
        res_sqrt_d  = res_sqrt_q;
        timeout_d   = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    idx_d     = 8'd0;
                    timeout_d = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                n_d     = vec_data;
                st_d    = 1'b1;
                tmo_d   = '0;
                state_d = S_REQ;
            end
            S_REQ: begin
                // A done level already high on entry counts as completion.
                if (done) begin
                    res_valid_d = 1'b1;
                    res_idx_d   = idx_q;
                    res_n_d     = n_q;
                    res_sqrt_d  = sqrt;
                    st_d        = 1'b0;
                    tmo_d       = '0;
                    state_d     = S_REL;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    st_d      = 1'b0;
                    state_d   = S_FINISH;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_REL: begin
                if (!done) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = S_FETCH;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 8'd0;
            n_q         <= '0;
            st_q        <= 1'b0;
            tmo_q       <= '0;
            res_valid_q <= 1'b0;
            res_idx_q   <= 8'd0;
            res_n_q     <= '0;
            res_sqrt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            n_q         <= n_d;
            st_q        <= st_d;
            tmo_q       <= tmo_d;
            res_valid_q <= res_valid_d;
            res_idx_q   <= res_idx_d;
            res_n_q     <= res_n_d;
            res_sqrt_q  <= res_sqrt_d;
            timeout_q   <= timeout_d;
        end
    end

`ifdef SQRT_SEQ_CHECK_EN
    localparam int EXT_W = 2 * R_W + 1;

    logic [R_W:0]     sqrt_p1;
    logic [2*R_W-1:0] sq;
    logic [EXT_W-1:0] sq1;
    logic [EXT_W-1:0] n_ext;
    logic             chk_ok;
    logic             res_ok_q;
    logic [7:0]       err_q;

    // Checked against the live responder result on the capture edge.
    assign sqrt_p1 = {1'b0, sqrt} + 1'b1;
    assign sq      = {{R_W{1'b0}}, sqrt} * {{R_W{1'b0}}, sqrt};
    assign sq1     = {{R_W{1'b0}}, sqrt_p1} * {{R_W{1'b0}}, sqrt_p1};
    assign n_ext   = EXT_W'(n_q);
    assign chk_ok  = ({1'b0, sq} <= n_ext) && (sq1 > n_ext);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_ok_q <= 1'b0;
            err_q    <= 8'd0;
        end else if (state_q == S_IDLE && go) begin
            err_q <= 8'd0;
        end else if (res_valid_d) begin
            res_ok_q <= chk_ok;
            if (!chk_ok && err_q != 8'hFF) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign res_ok    = res_ok_q;
    assign err_count = err_q;
`else
    assign res_ok    = 1'b1;
    assign err_count = 8'd0;
`endif

    assign vec_addr  = idx_q;
    assign st        = st_q;
    assign n         = n_q;
    assign busy      = (state_q != S_IDLE);
    assign res_valid = res_valid_q;
    assign res_idx   = res_idx_q;
    assign res_n     = res_n_q;
    assign res_sqrt  = res_sqrt_q;
    assign timeout   = timeout_q;
    assign run_done  = (state_q == S_FINISH);

endmodule

// File: tb/tb_sqrt_seq_master.sv
// tb/tb_sqrt_seq_master.sv - directed self-checking bench for sqrt_seq_master
// Expectations for res_ok/err_count follow SQRT_SEQ_CHECK_EN.
module tb_sqrt_seq_master;

    localparam int NUM_VEC = 16;
    localparam int N_W     = 8;
    localparam int R_W     = 4;
    localparam int TIMEOUT = 20;
`ifdef SQRT_SEQ_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic           clk;
    logic           rst;
    logic           go;
    logic [7:0]     vec_addr;
    logic [N_W-1:0] vec_data;
    logic           st;
    logic [N_W-1:0] n;
    logic           done;
    logic [R_W-1:0] sqrt;
    logic           busy;
    logic           res_valid;
    logic [7:0]     res_idx;
    logic [N_W-1:0] res_n;
    logic [R_W-1:0] res_sqrt;
    logic           res_ok;
    logic [7:0]     err_count;
    logic           timeout;
    logic           run_done;

    sqrt_seq_master #(
        .NUM_VEC(NUM_VEC),
        .N_W    (N_W),
        .R_W    (R_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .vec_addr (vec_addr),
        .vec_data (vec_data),
        .st       (st),
        .n        (n),
        .done     (done),
        .sqrt     (sqrt),
        .busy     (busy),
        .res_valid(res_valid),
        .res_idx  (res_idx),
        .res_n    (res_n),
        .res_sqrt (res_sqrt),
        .res_ok   (res_ok),
        .err_count(err_count),
        .timeout  (timeout),
        .run_done (run_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] tab    [16] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd8, 8'd15, 8'd16,
                                8'd24, 8'd25, 8'd63, 8'd64, 8'd100, 8'd143, 8'd144, 8'd255};
    logic [3:0] exp_sq [16] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd4,
                                4'd4, 4'd5, 4'd7, 4'd8, 4'd10, 4'd11, 4'd12, 4'd15};

    assign vec_data = tab[vec_addr[3:0]];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Responder: 5-cycle compute, optional wrong answer, stuck vector and slow release.
    bit fault_en  = 1'b0;
    int stuck_idx = -1;
    int rel_hold  = 0;

    function automatic logic [3:0] isqrt(input logic [7:0] v);
        for (int r = 15; r >= 0; r--) begin
            if (r * r <= int'(v)) return 4'(r);
        end
        return 4'd0;
    endfunction

    initial begin
        int         k;
        logic [3:0] r;
        done = 1'b0;
        sqrt = '0;
        forever begin
            @(posedge clk); #1;
            if (st && !done) begin
                k = 0;
                while (k < 4 && st) begin
                    @(posedge clk); #1;
                    k++;
                end
                if (st && int'(vec_addr) != stuck_idx) begin
                    r = isqrt(n);
                    if (fault_en && n == 8'd100) r = r + 4'd1;
                    sqrt = r;
                    done = 1'b1;
                    while (st) begin
                        @(posedge clk); #1;
                    end
                    for (int j = 0; j < rel_hold; j++) begin
                        @(posedge clk); #1;
                    end
                    done = 1'b0;
                end
            end
        end
    end

    int   cyc      = 0;
    int   vcount   = 0;
    int   rdcount  = 0;
    int   rise_cyc = 0;
    int   fall_cyc = 0;
    logic st_prev  = 1'b0;
    int   m_idx  [256];
    int   m_sqrt [256];
    int   m_ok   [256];

    always @(negedge clk) begin
        cyc     <= cyc + 1;
        st_prev <= st;
        if (st && !st_prev) rise_cyc <= cyc;
        if (!st && st_prev) fall_cyc <= cyc;
        if (res_valid) begin
            if (vcount < 256) begin
                m_idx[vcount]  <= int'(res_idx);
                m_sqrt[vcount] <= int'(res_sqrt);
                m_ok[vcount]   <= int'(res_ok);
            end
            vcount <= vcount + 1;
        end
        if (run_done) rdcount <= rdcount + 1;
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int seen;
        int w;
        seen = 0;
        w    = 0;
        while (!seen && w < 1500) begin
            tick();
            if (run_done) seen = 1;
            w++;
        end
        check_eq(tag, seen, 1);
    endtask

    task automatic check_run(input string tag, input int base, input int fault);
        int bad;
        for (int i = 0; i < NUM_VEC; i++) begin
            bad = (fault != 0 && i == 12) ? 1 : 0;
            check_eq($sformatf("%s_idx%0d", tag, i), m_idx[base+i], i);
            check_eq($sformatf("%s_sqrt%0d", tag, i), m_sqrt[base+i], int'(exp_sq[i]) + bad);
            check_eq($sformatf("%s_ok%0d", tag, i), m_ok[base+i], (bad != 0 && CHK != 0) ? 0 : 1);
        end
    endtask

    initial begin
        int         base;
        int         rd0;
        int         w;
        int         hold;
        int         bad_st;
        int         bad_n;
        int         g;
        logic [7:0] n_hold;

        rst = 1'b1;
        go  = 1'b0;
        repeat (3) tick();
        check_eq("rst_st", st, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_vec_addr", vec_addr, 0);
        check_eq("rst_n", n, 0);
        check_eq("rst_res_valid", res_valid, 0);
        check_eq("rst_res_sqrt", res_sqrt, 0);
        check_eq("rst_res_ok", res_ok, (CHK != 0) ? 0 : 1);
        check_eq("rst_err_count", err_count, 0);
        check_eq("rst_timeout", timeout, 0);
        check_eq("rst_run_done", run_done, 0);
        rst = 1'b0;
        tick();

        // Normal run
        base = vcount;
        rd0  = rdcount;
        pulse_go();
        wait_done("norm_done_seen");
        tick();
        check_eq("norm_count", vcount - base, 16);
        check_run("norm", base, 0);
        check_eq("norm_err", err_count, 0);
        check_eq("norm_timeout", timeout, 0);
        check_eq("norm_busy", busy, 0);
        check_eq("norm_run_done_cnt", rdcount - rd0, 1);

        // Wrong answer for n=100
        fault_en = 1'b1;
        base = vcount;
        pulse_go();
        wait_done("fault_done_seen");
        tick();
        check_eq("fault_count", vcount - base, 16);
        check_run("fault", base, 1);
        check_eq("fault_err", err_count, CHK);
        fault_en = 1'b0;

        // Asynchronous reset while st is high
        pulse_go();
        w = 0;
        while (!(st && vec_addr == 8'd2) && w < 500) begin
            tick();
            w++;
        end
        tick();
        check_eq("rstmid_st_pre", st, 1);
        #2 rst = 1'b1;
        #1;
        check_eq("rstmid_st", st, 0);
        check_eq("rstmid_busy", busy, 0);
        check_eq("rstmid_n", n, 0);
        check_eq("rstmid_vec_addr", vec_addr, 0);
        check_eq("rstmid_res_idx", res_idx, 0);
        check_eq("rstmid_res_sqrt", res_sqrt, 0);
        check_eq("rstmid_err", err_count, 0);
        tick();
        rst = 1'b0;
        tick();
        base = vcount;
        pulse_go();
        check_eq("restart_busy", busy, 1);
        check_eq("restart_vec_addr", vec_addr, 0);
        check_eq("restart_err", err_count, 0);
        wait_done("restart_done_seen");
        tick();
        check_eq("restart_count", vcount - base, 16);

        // Responder never answers vector 3
        stuck_idx = 3;
        base = vcount;
        rd0  = rdcount;
        pulse_go();
        wait_done("stuck_done_seen");
        tick();
        check_eq("stuck_st_len", fall_cyc - rise_cyc, TIMEOUT);
        check_eq("stuck_timeout", timeout, 1);
        check_eq("stuck_count", vcount - base, 3);
        check_eq("stuck_busy", busy, 0);
        check_eq("stuck_run_done_cnt", rdcount - rd0, 1);
        stuck_idx = -1;

        // done held 10 cycles after st falls
        rel_hold = 10;
        base = vcount;
        pulse_go();
        check_eq("slow_timeout_clr", timeout, 0);
        w = 0;
        while (!(done && vec_addr == 8'd5) && w < 500) begin
            tick();
            w++;
        end
        check_eq("slow_reach", (done && vec_addr == 8'd5) ? 1 : 0, 1);
        tick();
        n_hold = n;
        hold   = 0;
        bad_st = 0;
        bad_n  = 0;
        while (done && hold < 50) begin
            if (st) bad_st++;
            if (n != n_hold) bad_n++;
            hold++;
            tick();
        end
        check_eq("slow_hold_len", hold, 10);
        check_eq("slow_st_low", bad_st, 0);
        check_eq("slow_n_stable", bad_n, 0);
        check_eq("slow_n_value", n_hold, 8);
        g = 0;
        while (!st && g < 20) begin
            g++;
            tick();
        end
        check_eq("slow_rise_cycle", g + 1, 3);
        wait_done("slow_done_seen");
        tick();
        check_eq("slow_count", vcount - base, 16);
        check_run("slow", base, 0);
        rel_hold = 0;

        // go held for two full runs
        base = vcount;
        rd0  = rdcount;
        go   = 1'b1;
        tick();
        wait_done("retrig_done1_seen");
        check_eq("retrig_count1", vcount - base, 16);
        check_run("retrig", base, 0);
        tick();
        check_eq("retrig_idle_busy", busy, 0);
        tick();
        check_eq("retrig_second_busy", busy, 1);
        check_eq("retrig_second_addr", vec_addr, 0);
        go = 1'b0;
        wait_done("retrig_done2_seen");
        tick();
        check_eq("retrig_run_done_cnt", rdcount - rd0, 2);
        check_eq("retrig_count2", vcount - base, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
